// File: rtl/apbmst.sv
// APB master: takes one command at a time from a valid/ready command port
// and runs it as an APB SETUP/ACCESS transfer. A transfer that sees PREADY
// low for TIMEOUT_CYCLES consecutive ACCESS cycles is aborted.
// Ports:
//   I_APBMST_PCLK, I_APBMST_PRESET_N   clock, synchronous active-low reset
//   I_APBMST_CMD_*  / O_APBMST_CMD_READY  command request (CMD_READY is comb)
//   O_APBMST_RSP_*                        completion pulse, read data, abort flag
//   O_APBMST_TIMEOUT_CNT                  saturating count of aborts
//   O_APBMST_P* / I_APBMST_P*             APB master signals
module apbmst #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        I_APBMST_PCLK,
   input  logic        I_APBMST_PRESET_N,
   input  logic        I_APBMST_CMD_VALID,
   output logic        O_APBMST_CMD_READY,
   input  logic        I_APBMST_CMD_WRITE,
   input  logic [31:0] I_APBMST_CMD_ADDR,
   input  logic [31:0] I_APBMST_CMD_WDATA,
   output logic        O_APBMST_RSP_VALID,
   output logic [31:0] O_APBMST_RSP_RDATA,
   output logic        O_APBMST_RSP_TIMEOUT,
   output logic [7:0]  O_APBMST_TIMEOUT_CNT,
   output logic [31:0] O_APBMST_PADDR,
   output logic [31:0] O_APBMST_PWDATA,
   output logic        O_APBMST_PWRITE,
   output logic        O_APBMST_PSEL,
   output logic        O_APBMST_PENABLE,
   input  logic [31:0] I_APBMST_PRDATA,
   input  logic        I_APBMST_PREADY
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
   logic [AW-1:0]   paddr_nxt;
   logic [DW-1:0]   pwdata_nxt, rdata_nxt;
   logic            pwrite_nxt, psel_nxt, penable_nxt;
   logic            rsp_valid_nxt, rsp_timeout_nxt;
   logic [CW-1:0]   tocnt_nxt;

   logic            accept_c, done_c, abort_c;

   // Handshake and ACCESS-cycle termination conditions
   assign O_APBMST_CMD_READY = (state == ST_IDLE);
   assign accept_c = I_APBMST_CMD_VALID && (state == ST_IDLE);
   assign done_c   = (state == ST_ACCESS) && I_APBMST_PREADY;
   // Last allowed wait cycle: wait_cnt already holds TIMEOUT_CYCLES-1 low cycles
   assign abort_c  = (state == ST_ACCESS) && !I_APBMST_PREADY &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   // State and output registers
   always_ff @(posedge I_APBMST_PCLK) begin
      if (!I_APBMST_PRESET_N) begin
         state                <= ST_IDLE;
         wait_cnt             <= '0;
         O_APBMST_PADDR       <= '0;
         O_APBMST_PWDATA      <= '0;
         O_APBMST_PWRITE      <= 1'b0;
         O_APBMST_PSEL        <= 1'b0;
         O_APBMST_PENABLE     <= 1'b0;
         O_APBMST_RSP_VALID   <= 1'b0;
         O_APBMST_RSP_TIMEOUT <= 1'b0;
         O_APBMST_RSP_RDATA   <= '0;
         O_APBMST_TIMEOUT_CNT <= '0;
      end else begin
         state                <= state_nxt;
         wait_cnt             <= wait_cnt_nxt;
         O_APBMST_PADDR       <= paddr_nxt;
         O_APBMST_PWDATA      <= pwdata_nxt;
         O_APBMST_PWRITE      <= pwrite_nxt;
         O_APBMST_PSEL        <= psel_nxt;
         O_APBMST_PENABLE     <= penable_nxt;
         O_APBMST_RSP_VALID   <= rsp_valid_nxt;
         O_APBMST_RSP_TIMEOUT <= rsp_timeout_nxt;
         O_APBMST_RSP_RDATA   <= rdata_nxt;
         O_APBMST_TIMEOUT_CNT <= tocnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept_c) state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: if (done_c || abort_c) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      wait_cnt_nxt    = wait_cnt;
      paddr_nxt       = O_APBMST_PADDR;
      pwdata_nxt      = O_APBMST_PWDATA;
      pwrite_nxt      = O_APBMST_PWRITE;
      rdata_nxt       = O_APBMST_RSP_RDATA;
      tocnt_nxt       = O_APBMST_TIMEOUT_CNT;
      psel_nxt        = (state_nxt != ST_IDLE);
      penable_nxt     = (state_nxt == ST_ACCESS);
      rsp_valid_nxt   = done_c || abort_c;
      rsp_timeout_nxt = abort_c;

      if (accept_c) begin
         // Word-align by masking so every address bit is consumed
         paddr_nxt    = I_APBMST_CMD_ADDR & ~AW'(3);
         pwrite_nxt   = I_APBMST_CMD_WRITE;
         pwdata_nxt   = I_APBMST_CMD_WRITE ? I_APBMST_CMD_WDATA : '0;
         wait_cnt_nxt = '0;
      end

      if (state == ST_ACCESS && !I_APBMST_PREADY && !abort_c)
         wait_cnt_nxt = wait_cnt + CW'(1);

      if (done_c && !O_APBMST_PWRITE)
         rdata_nxt = I_APBMST_PRDATA;

      if (abort_c) begin
         rdata_nxt = '0;
         if (O_APBMST_TIMEOUT_CNT != {CW{1'b1}})
            tocnt_nxt = O_APBMST_TIMEOUT_CNT + CW'(1);
      end
   end

endmodule

// File: tb/tb_apbmst.sv
// Directed bench for apbmst (TIMEOUT_CYCLES = 4): a vector table of single
// transfers with a slave that holds PREADY low for a set number of ACCESS
// cycles, plus hand-written back-to-back, saturation and reset sequences.
module tb_apbmst;

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [7:0]  tocnt;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, psel, penable, pready;

   int total = 0;
   int bad   = 0;
   int exp_tocnt;

   apbmst #(.TIMEOUT_CYCLES(4)) dut (
      .I_APBMST_PCLK        (clk),
      .I_APBMST_PRESET_N    (rst_n),
      .I_APBMST_CMD_VALID   (cmd_valid),
      .O_APBMST_CMD_READY   (cmd_ready),
      .I_APBMST_CMD_WRITE   (cmd_write),
      .I_APBMST_CMD_ADDR    (cmd_addr),
      .I_APBMST_CMD_WDATA   (cmd_wdata),
      .O_APBMST_RSP_VALID   (rsp_valid),
      .O_APBMST_RSP_RDATA   (rsp_rdata),
      .O_APBMST_RSP_TIMEOUT (rsp_timeout),
      .O_APBMST_TIMEOUT_CNT (tocnt),
      .O_APBMST_PADDR       (paddr),
      .O_APBMST_PWDATA      (pwdata),
      .O_APBMST_PWRITE      (pwrite),
      .O_APBMST_PSEL        (psel),
      .O_APBMST_PENABLE     (penable),
      .I_APBMST_PRDATA      (prdata),
      .I_APBMST_PREADY      (pready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;     // ACCESS cycles with PREADY low before it rises
      logic [31:0] prdata;
      logic [31:0] e_paddr;
      logic [31:0] e_pwdata;
      logic [31:0] e_rdata;
      logic        e_to;
      int          e_access;
      logic [7:0]  e_tocnt;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // One complete transfer, checked phase by phase; returns with DUT idle
   task automatic run_xfer(input vec_t v);
      int  n;
      bit  fin;
      @(negedge clk);
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      pready    = 1'b1;            // must be ignored outside ACCESS
      prdata    = 32'hBAD0_BAD0;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = ~v.wr;           // scramble command after acceptance
      cmd_addr  = 32'hFFFF_FFFF;
      cmd_wdata = 32'h5555_AAAA;
      chk("setup_psel",    32'(psel), 32'd1);
      chk("setup_penable", 32'(penable), 32'd0);
      chk("setup_paddr",   paddr, v.e_paddr);
      chk("setup_pwdata",  pwdata, v.e_pwdata);
      chk("setup_pwrite",  32'(pwrite), 32'(v.wr));
      chk("setup_ready",   32'(cmd_ready), 32'd0);
      chk("setup_rspv",    32'(rsp_valid), 32'd0);
      n   = 0;
      fin = 0;
      for (int i = 0; i < 300 && !fin; i++) begin
         @(negedge clk);
         if (psel && penable) begin
            n++;
            pready = (n > v.waits);
            prdata = v.prdata;
            chk("access_paddr",  paddr, v.e_paddr);
            chk("access_pwdata", pwdata, v.e_pwdata);
            chk("access_pwrite", 32'(pwrite), 32'(v.wr));
         end else begin
            fin = 1;
         end
      end
      pready = 1'b0;
      prdata = 32'hDEAD_0000;
      chk("access_cycles", 32'(n), 32'(v.e_access));
      chk("rsp_valid",     32'(rsp_valid), 32'd1);
      chk("rsp_timeout",   32'(rsp_timeout), 32'(v.e_to));
      chk("rsp_rdata",     rsp_rdata, v.e_rdata);
      chk("timeout_cnt",   32'(tocnt), 32'(v.e_tocnt));
      chk("done_psel",     32'(psel), 32'd0);
      chk("done_ready",    32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
      chk("idle_paddr",    paddr, v.e_paddr);
   endtask

   vec_t tv;

   initial begin
      // wr addr wdata waits prdata | paddr pwdata rdata to access tocnt
      vecs[0] = '{1'b1, 32'h0000_0020, 32'h0000_0001, 1, 32'h0,
                  32'h0000_0020, 32'h0000_0001, 32'h0, 1'b0, 2, 8'd0};
      vecs[1] = '{1'b0, 32'h0000_0013, 32'h1234_5678, 0, 32'h0000_00C8,
                  32'h0000_0010, 32'h0, 32'h0000_00C8, 1'b0, 1, 8'd0};
      vecs[2] = '{1'b1, 32'hABCD_1237, 32'hDEAD_BEEF, 0, 32'h1111_1111,
                  32'hABCD_1234, 32'hDEAD_BEEF, 32'h0000_00C8, 1'b0, 1, 8'd0};
      vecs[3] = '{1'b0, 32'h0000_0100, 32'h0, 3, 32'h1234_5678,
                  32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0, 4, 8'd0};
      vecs[4] = '{1'b0, 32'h0000_0044, 32'h0, 10, 32'h9999_9999,
                  32'h0000_0044, 32'h0, 32'h0, 1'b1, 4, 8'd1};
      vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 2, 32'h0000_A5A5,
                  32'hFFFF_FFFC, 32'h0, 32'h0000_A5A5, 1'b0, 3, 8'd1};
      vecs[6] = '{1'b1, 32'h0000_0008, 32'h0000_0005, 99, 32'h0,
                  32'h0000_0008, 32'h0000_0005, 32'h0, 1'b1, 4, 8'd2};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; prdata = '0; pready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_psel",    32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_pwrite",  32'(pwrite), 32'd0);
      chk("rst_paddr",   paddr, 32'h0);
      chk("rst_pwdata",  pwdata, 32'h0);
      chk("rst_rspv",    32'(rsp_valid), 32'd0);
      chk("rst_rspto",   32'(rsp_timeout), 32'd0);
      chk("rst_rdata",   rsp_rdata, 32'h0);
      chk("rst_tocnt",   32'(tocnt), 32'd0);
      chk("rst_ready",   32'(cmd_ready), 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

      // Back-to-back: CMD_VALID held, zero-wait slave
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h11;
      pready = 1'b1; prdata = 32'h0000_0077;
      @(negedge clk);
      chk("b2b_a_setup_psel", 32'(psel), 32'd1);
      chk("b2b_a_paddr",      paddr, 32'h40);
      cmd_write = 1'b0; cmd_addr = 32'h84; cmd_wdata = 32'hFFFF_0000;
      @(negedge clk);
      chk("b2b_a_penable", 32'(penable), 32'd1);
      chk("b2b_a_pwdata",  pwdata, 32'h11);
      @(negedge clk);
      chk("b2b_rspv",  32'(rsp_valid), 32'd1);
      chk("b2b_gap",   32'(psel), 32'd0);
      chk("b2b_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("b2b_b_psel",    32'(psel), 32'd1);
      chk("b2b_b_penable", 32'(penable), 32'd0);
      chk("b2b_b_paddr",   paddr, 32'h84);
      chk("b2b_b_pwrite",  32'(pwrite), 32'd0);
      chk("b2b_b_pwdata",  pwdata, 32'h0);
      chk("b2b_b_rspv",    32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("b2b_b_access", 32'(penable), 32'd1);
      @(negedge clk);
      chk("b2b_b_rspv_end", 32'(rsp_valid), 32'd1);
      chk("b2b_b_rdata",    rsp_rdata, 32'h77);
      chk("b2b_b_to",       32'(rsp_timeout), 32'd0);
      pready = 1'b0;

      // Abort counter saturation
      exp_tocnt = 2;
      tv = vecs[4];
      for (int k = 0; k < 256; k++) begin
         exp_tocnt = (exp_tocnt < 255) ? exp_tocnt + 1 : 255;
         tv.e_tocnt = 8'(exp_tocnt);
         run_xfer(tv);
      end
      chk("sat_tocnt", 32'(tocnt), 32'd255);
      tv = vecs[3];
      tv.e_tocnt = 8'd255;
      run_xfer(tv);

      // Reset in the middle of ACCESS
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; pready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rstacc_in_access", 32'(penable), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstacc_psel",    32'(psel), 32'd0);
      chk("rstacc_penable", 32'(penable), 32'd0);
      chk("rstacc_rspv",    32'(rsp_valid), 32'd0);
      chk("rstacc_tocnt",   32'(tocnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstacc_ready", 32'(cmd_ready), 32'd1);
      chk("rstacc_rspv2", 32'(rsp_valid), 32'd0);
      tv = vecs[1];
      tv.e_tocnt = 8'd0;
      run_xfer(tv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apbmst.md
APBMST -- requirements
Module: apbmst

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, consecutive ACCESS cycles with PREADY low before abort (legal 1..255).
REQ-002 SHALL have port: I_APBMST_PCLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: I_APBMST_PRESET_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: I_APBMST_CMD_VALID  input  1  command request.
REQ-005 SHALL have port: O_APBMST_CMD_READY  output  1  command accepted when high with CMD_VALID.
REQ-006 SHALL have port: I_APBMST_CMD_WRITE  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: I_APBMST_CMD_ADDR  input  32  byte address.
REQ-008 SHALL have port: I_APBMST_CMD_WDATA  input  32  write data.
REQ-009 SHALL have port: O_APBMST_RSP_VALID  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: O_APBMST_RSP_RDATA  output  32  read data of last completed read.
REQ-011 SHALL have port: O_APBMST_RSP_TIMEOUT  output  1  qualifies RSP_VALID; 1 = aborted.
REQ-012 SHALL have port: O_APBMST_TIMEOUT_CNT  output  8  saturating abort counter.
REQ-013 SHALL have ports: O_APBMST_PADDR (32), O_APBMST_PWDATA (32), O_APBMST_PWRITE (1), O_APBMST_PSEL (1), O_APBMST_PENABLE (1) outputs; I_APBMST_PRDATA (32), I_APBMST_PREADY (1) inputs.

Function
REQ-014 SHALL implement states IDLE, SETUP, ACCESS; all outputs registered except CMD_READY, which equals (state == IDLE).
REQ-015 SHALL accept a command on a rising edge where CMD_VALID and CMD_READY are both high; state moves IDLE -> SETUP.
REQ-016 SHALL latch ADDR with bits [1:0] forced to 0, WRITE, and WDATA on acceptance; for reads, WDATA latches as 0.
REQ-017 SHALL drive in SETUP: PSEL=1, PENABLE=0, with PADDR, PWRITE and PWDATA valid.
REQ-018 SHALL go SETUP -> ACCESS unconditionally after one cycle; in ACCESS it drives PSEL=1, PENABLE=1.
REQ-019 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP through the final ACCESS cycle.
REQ-020 SHALL complete normally on the first ACCESS cycle with PREADY=1: capture PRDATA into RSP_RDATA for reads (unchanged for writes), then go ACCESS -> IDLE.
REQ-021 SHALL count ACCESS cycles with PREADY=0 in an 8-bit wait counter, cleared on entering SETUP.
REQ-022 SHALL abort when PREADY=0 in the TIMEOUT_CYCLES-th consecutive ACCESS cycle: go to IDLE, set RSP_RDATA=0, increment TIMEOUT_CNT (saturating at 255).
REQ-023 SHALL give normal completion priority over abort when PREADY=1 in the TIMEOUT_CYCLES-th ACCESS cycle.
REQ-024 SHALL pulse RSP_VALID for exactly the first IDLE cycle after completion or abort; RSP_TIMEOUT=1 only with an abort pulse, else 0.
REQ-025 SHALL allow a new command to be accepted in the same cycle RSP_VALID is high (back-to-back), giving a minimum of 3 cycles per transfer with zero wait states.
REQ-026 SHALL deassert PSEL and PENABLE in IDLE; PADDR, PWDATA and PWRITE hold their last values.
REQ-027 SHALL ignore PREADY and PRDATA outside ACCESS.

Reset
REQ-028 SHALL, on any edge with PRESET_N=0, force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, RSP_VALID=0, RSP_TIMEOUT=0, RSP_RDATA=0, TIMEOUT_CNT=0 and wait counter=0.
REQ-029 SHALL, on reset during SETUP or ACCESS, abandon the transfer with no RSP_VALID pulse and no TIMEOUT_CNT change.

Verification
REQ-030 SHALL cover: write 0x0000_0020 <- 0x1, slave PREADY high in 2nd ACCESS cycle -> PADDR=0x20, PWDATA=0x1, PWRITE=1, one SETUP cycle, two ACCESS cycles, RSP_VALID pulse with TIMEOUT=0.
REQ-031 SHALL cover: read addr 0x13, PRDATA=0x0000_00C8 with PREADY in 1st ACCESS cycle -> PADDR=0x10, PWDATA=0, RSP_RDATA=0xC8, RSP_VALID 3 cycles after acceptance.
REQ-032 SHALL cover: TIMEOUT_CYCLES=4, PREADY held low -> exactly 4 ACCESS cycles, RSP_VALID with TIMEOUT=1, RSP_RDATA=0, TIMEOUT_CNT=1; repeat 255 times more -> TIMEOUT_CNT stays 255.
REQ-033 SHALL cover: TIMEOUT_CYCLES=4, PREADY=1 in 4th ACCESS cycle -> normal completion, TIMEOUT=0, TIMEOUT_CNT unchanged.
REQ-034 SHALL cover: CMD_VALID held high for two commands, zero-wait slave -> second acceptance in the RSP_VALID cycle, PSEL low for exactly one cycle between transfers.
REQ-035 SHALL cover: PRESET_N low in an ACCESS cycle -> next cycle PSEL=0, PENABLE=0, no RSP_VALID, CMD_READY=1 after reset release.
